// File: rtl/awgn_pkg.sv
// Shared types and helpers for the AWGN BER checker: run-state encoding and
// the per-axis QPSK hard decision.
package awgn_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int NUM_SYM_DEF = 320000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ber_state_t;

  // A negative sample decides to bit 1; zero and positive decide to bit 0.
  function automatic logic qpsk_decide(input logic sample_msb);
    return sample_msb;
  endfunction

endpackage

// File: rtl/awgn_ber_counter_fifo.sv
// Reference-bit FIFO: 2-bit entries, power-of-two depth, extra pointer bit
// separates full from empty. Synchronous clear empties it in one cycle.
module bit_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] din,
  output logic [1:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [1:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop on the same cycle frees the slot a full-FIFO push needs.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/awgn_ber_counter.sv
// QPSK hard-decision BER counter with reference-bit FIFO.
// Optional noise-power accumulator enabled by macro AWGN_BER_NOISE_PWR_EN.
module awgn_ber_counter
  import awgn_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_SYM    = NUM_SYM_DEF,
  parameter int CNT_W      = 20,
  parameter int FIFO_DEPTH = 16,
  parameter int AMP        = 8192
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              tx_valid,
  input  logic [1:0]        tx_bits,
  output logic              tx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] y_in_real,
  input  logic [DATA_W-1:0] y_in_imagi,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sym_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              underflow,
  output logic [47:0]       noise_pwr,
  output ber_state_t        state
);

  localparam logic [CNT_W-1:0] NUM_SYM_C = CNT_W'(NUM_SYM);

  ber_state_t       state_q, state_d;
  logic [CNT_W-1:0] sym_q, err_q;
  logic             underflow_q, busy_q, done_q;
  logic             run, enter_run;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]       fifo_dout;
  logic             compare;
  logic [1:0]       decision, bit_diff, errs;
  logic [CNT_W:0]   sym_sum, err_sum;
  logic [CNT_W-1:0] sym_next, err_next;

  assign run       = (state_q == RUN);
  assign enter_run = start && !run;

  // tx handshake: a pair transfers on a cycle where tx_valid && tx_ready;
  // tx_ready depends only on state and FIFO full. rx has no backpressure.
  assign tx_ready  = run && !fifo_full;
  assign fifo_push = tx_valid && tx_ready;
  assign fifo_pop  = run && rx_valid;
  assign compare   = fifo_pop && !fifo_empty;

  bit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (enter_run),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (tx_bits),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign decision = {qpsk_decide(y_in_real[DATA_W-1]), qpsk_decide(y_in_imagi[DATA_W-1])};
  assign bit_diff = decision ^ fifo_dout;
  assign errs     = {1'b0, bit_diff[1]} + {1'b0, bit_diff[0]};

  // Saturating updates: the carry out of the widened sum selects all-ones.
  assign sym_sum  = {1'b0, sym_q} + (CNT_W+1)'(1);
  assign err_sum  = {1'b0, err_q} + (CNT_W+1)'(errs);
  assign sym_next = sym_sum[CNT_W] ? '1 : sym_sum[CNT_W-1:0];
  assign err_next = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (compare && (sym_next == NUM_SYM_C)) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sym_q       <= '0;
      err_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
      if (enter_run) begin
        sym_q       <= '0;
        err_q       <= '0;
        underflow_q <= 1'b0;
      end else if (fifo_pop) begin
        if (fifo_empty) begin
          underflow_q <= 1'b1;
        end else begin
          sym_q <= sym_next;
          err_q <= err_next;
        end
      end
    end
  end

  assign state     = state_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sym_count = sym_q;
  assign err_count = err_q;
  assign underflow = underflow_q;

`ifdef AWGN_BER_NOISE_PWR_EN
  localparam int SQ_W = 2*DATA_W + 2;
  localparam logic signed [DATA_W:0] AMP_P = (DATA_W+1)'(AMP);
  localparam logic signed [DATA_W:0] AMP_N = (DATA_W+1)'(-AMP);

  logic signed [DATA_W:0] d_i, d_q, d_i_q, d_q_q;
  logic signed [SQ_W-1:0] di_ext, dq_ext, sq_i, sq_q;
  logic [SQ_W:0]          sq_sum, sq_sum_q;
  logic [48:0]            acc_sum;
  logic [47:0]            acc_q;
  logic                   v1_q, v2_q;

  assign d_i = $signed({y_in_real[DATA_W-1], y_in_real}) - (fifo_dout[1] ? AMP_N : AMP_P);
  assign d_q = $signed({y_in_imagi[DATA_W-1], y_in_imagi}) - (fifo_dout[0] ? AMP_N : AMP_P);

  assign di_ext  = SQ_W'(d_i_q);
  assign dq_ext  = SQ_W'(d_q_q);
  assign sq_i    = di_ext * di_ext;
  assign sq_q    = dq_ext * dq_ext;
  assign sq_sum  = {1'b0, sq_i} + {1'b0, sq_q};
  assign acc_sum = {1'b0, acc_q} + 49'(sq_sum_q);

  // Stage 1 registers differences, stage 2 squares, then the accumulator.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_i_q    <= '0;
      d_q_q    <= '0;
      v1_q     <= 1'b0;
      sq_sum_q <= '0;
      v2_q     <= 1'b0;
      acc_q    <= '0;
    end else if (enter_run) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      acc_q <= '0;
    end else begin
      v1_q <= compare;
      if (compare) begin
        d_i_q <= d_i;
        d_q_q <= d_q;
      end
      v2_q <= v1_q;
      if (v1_q) sq_sum_q <= sq_sum;
      if (v2_q) acc_q <= acc_sum[48] ? '1 : acc_sum[47:0];
    end
  end

  assign noise_pwr = acc_q;
`else
  logic unused_sample_bits;
  assign unused_sample_bits = ^{y_in_real[DATA_W-2:0], y_in_imagi[DATA_W-2:0]};
  assign noise_pwr = '0;
`endif

endmodule

// File: tb/tb_awgn_ber_counter.sv
// Bench for awgn_ber_counter: table vectors, hand sequences for multi-cycle
// corners, then random traffic against a queue-based reference model.
module tb_awgn_ber_counter;
  import awgn_pkg::*;

  localparam int DATA_W  = 16;
  localparam int NUM_SYM = 8;
  localparam int CNT_W   = 4;
  localparam int DEPTH   = 16;
  localparam int AMP     = 8192;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              start, tx_valid, rx_valid;
  logic [1:0]        tx_bits;
  logic              tx_ready, busy, done, underflow;
  logic [DATA_W-1:0] y_in_real, y_in_imagi;
  logic [CNT_W-1:0]  sym_count, err_count;
  logic [47:0]       noise_pwr;
  ber_state_t        dut_state;

  awgn_ber_counter #(
    .DATA_W(DATA_W), .NUM_SYM(NUM_SYM), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH), .AMP(AMP)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .tx_valid(tx_valid), .tx_bits(tx_bits),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .y_in_real(y_in_real), .y_in_imagi(y_in_imagi),
    .busy(busy), .done(done), .sym_count(sym_count), .err_count(err_count),
    .underflow(underflow), .noise_pwr(noise_pwr), .state(dut_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // reference model and scoreboard
  int         n_cmp = 0;
  int         n_err = 0;
  int         m_mode, m_sym, m_err;
  bit         m_uf;
  longint     m_noise;
  longint     m_hist[$];
  logic [1:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_sym = 0; m_err = 0; m_uf = 0; m_noise = 0;
    exp_q.delete(); m_hist = '{0, 0};
  endtask

  task automatic model_edge(input bit st, input bit tv, input logic [1:0] tb,
                            input bit rv, input int yr, input int yi);
    bit         was_full;
    longint     add;
    logic [1:0] pair;
    int         e, ii, iq;
    add = 0;
    was_full = (exp_q.size() >= DEPTH);
    if (st && m_mode != M_RUN) begin
      m_mode = M_RUN; m_sym = 0; m_err = 0; m_uf = 0; m_noise = 0;
      exp_q.delete(); m_hist = '{0, 0};
      return;
    end
    m_noise += m_hist.pop_front();
    if (m_mode == M_RUN) begin
      if (rv) begin
        if (exp_q.size() == 0) m_uf = 1;
        else begin
          pair = exp_q.pop_front();
          e = (((yr < 0) ? 1'b1 : 1'b0) != pair[1] ? 1 : 0) + (((yi < 0) ? 1'b1 : 1'b0) != pair[0] ? 1 : 0);
          m_sym = (m_sym + 1 > CNT_MAX) ? CNT_MAX : m_sym + 1;
          m_err = (m_err + e > CNT_MAX) ? CNT_MAX : m_err + e;
          ii = pair[1] ? -AMP : AMP;
          iq = pair[0] ? -AMP : AMP;
          add = longint'(yr - ii) * longint'(yr - ii) + longint'(yi - iq) * longint'(yi - iq);
          if (m_sym == NUM_SYM) m_mode = M_DONE;
        end
      end
      if (tv && !was_full) exp_q.push_back(tb);
    end
    m_hist.push_back(add);
  endtask

  function automatic longint exp_noise();
`ifdef AWGN_BER_NOISE_PWR_EN
    return m_noise;
`else
    return 0;
`endif
  endfunction

  task automatic check_all();
    check("busy", busy, m_mode == M_RUN);
    check("done", done, m_mode == M_DONE);
    check("tx_ready", tx_ready, (m_mode == M_RUN) && (exp_q.size() < DEPTH));
    check("sym_count", sym_count, m_sym);
    check("err_count", err_count, m_err);
    check("underflow", underflow, m_uf);
    check("noise_pwr", noise_pwr, exp_noise());
  endtask

  // driver
  task automatic step(input bit st, input bit tv, input logic [1:0] tb,
                      input bit rv, input int yr, input int yi);
    start = st; tx_valid = tv; tx_bits = tb; rx_valid = rv;
    y_in_real = DATA_W'(yr); y_in_imagi = DATA_W'(yi);
    @(posedge clock);
    model_edge(st, tv, tb, rv, yr, yi);
    #1;
    check_all();
    start = 0; tx_valid = 0; rx_valid = 0;
  endtask

  function automatic int rand_sample();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return $urandom_range(0, 1) ? 1 : -1;
      2: return AMP - 50 + int'($urandom_range(0, 100));
      3: return -AMP - 50 + int'($urandom_range(0, 100));
      4: return $urandom_range(0, 1) ? 32767 : -32768;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  typedef struct {
    bit         st, tv, rv;
    logic [1:0] tb;
    int         yr, yi;
    int         e_sym, e_err;
    bit         e_busy, e_done;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit st, bit tv, logic [1:0] tb, bit rv, int yr, int yi,
                              int es, int ee, bit eb, bit ed);
    vec_t v;
    v.st = st; v.tv = tv; v.tb = tb; v.rv = rv; v.yr = yr; v.yi = yi;
    v.e_sym = es; v.e_err = ee; v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  initial begin
    int yr_t[4];
    int yi_t[4];
    logic [1:0] pat;
    yr_t = '{100, 100, -100, -100};
    yi_t = '{100, -100, 100, -100};

    // zero-error run: pairs 00,01,10,11 repeating, matching samples
    vt.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 8; i++) begin
      pat = 2'(i % 4);
      vt.push_back(mk(0, 1, pat, 0, 0, 0, 0, 0, 1, 0));
    end
    for (int i = 0; i < 8; i++)
      vt.push_back(mk(0, 0, 2'b00, 1, yr_t[i%4], yi_t[i%4], i + 1, 0, i != 7, i == 7));
    // forced errors, restarted from DONE
    vt.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) vt.push_back(mk(0, 1, 2'b00, 0, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 2'b00, 1, -5,  5, 1, 1, 1, 0));
    vt.push_back(mk(0, 0, 2'b00, 1, -5, -5, 2, 3, 1, 0));
    vt.push_back(mk(0, 0, 2'b00, 1,  0,  0, 3, 3, 1, 0));
    vt.push_back(mk(0, 0, 2'b00, 1,  5,  5, 4, 3, 1, 0));

    start = 0; tx_valid = 0; tx_bits = 0; rx_valid = 0; y_in_real = 0; y_in_imagi = 0;
    reset = 0;
    model_reset();
    #3;
    check_all();
    @(negedge clock);
    reset = 1;
    step(0, 1, 2'b11, 1, -3, -3);  // ignored in IDLE

    foreach (vt[i]) begin
      step(vt[i].st, vt[i].tv, vt[i].tb, vt[i].rv, vt[i].yr, vt[i].yi);
      check("tbl_sym", sym_count, vt[i].e_sym);
      check("tbl_err", err_count, vt[i].e_err);
      check("tbl_busy", busy, vt[i].e_busy);
      check("tbl_done", done, vt[i].e_done);
    end

    // underflow, then simultaneous push with empty pop
    step(0, 0, 2'b00, 1, 9, 9);
    check("uf_set", underflow, 1);
    check("uf_sym", sym_count, 4);
    step(0, 1, 2'b10, 1, 9, 9);
    step(0, 0, 2'b00, 1, -7, 7);
    check("uf_push_kept_sym", sym_count, 5);
    check("uf_push_kept_err", err_count, 3);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b11, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 1, 1, 1);
    check("run_end_done", done, 1);
    check("run_end_err", err_count, 9);
    step(1, 0, 2'b00, 0, 0, 0);
    check("restart_uf", underflow, 0);
    check("restart_sym", sym_count, 0);

    // full FIFO
    for (int i = 0; i < DEPTH; i++) step(0, 1, 2'($urandom_range(0, 3)), 0, 0, 0);
    check("full_ready", tx_ready, 0);
    step(0, 1, 2'b01, 0, 0, 0);
    check("held_ready", tx_ready, 0);
    step(0, 1, 2'b01, 1, rand_sample(), rand_sample());
    check("pop_full_ready", tx_ready, 1);
    step(0, 1, 2'b01, 1, rand_sample(), rand_sample());
    check("pushpop_ready", tx_ready, 1);
    step(0, 1, 2'b10, 0, 0, 0);
    check("refull_ready", tx_ready, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 2'b00, 1, rand_sample(), rand_sample());
    check("full_run_done", done, 1);

    // error-count saturation
    step(1, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 2'b11, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 2'b00, 1, 1, 1);
    check("sat_err", err_count, CNT_MAX);
    check("sat_sym", sym_count, 8);

    // asynchronous reset mid-run
    step(1, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b01, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 1, 4, -4);
    #3;
    reset = 0;
    #1;
    model_reset();
    check("rst_sym", sym_count, 0);
    check("rst_busy", busy, 0);
    check_all();
    @(negedge clock);
    reset = 1;
    step(1, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 2'b10, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 2'b00, 1, -20, 20);
    check("post_rst_done", done, 1);

    // noise power
    step(1, 0, 2'b00, 0, 0, 0);
    step(0, 1, 2'b00, 0, 0, 0);
    step(0, 0, 2'b00, 1, 8202, 8182);
    check("np_sym", sym_count, 1);
    step(0, 0, 2'b00, 0, 0, 0);
    step(0, 0, 2'b00, 0, 0, 0);
`ifdef AWGN_BER_NOISE_PWR_EN
    check("np_value", noise_pwr, 200);
`else
    check("np_value", noise_pwr, 0);
`endif

    // random traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 24) == 0, $urandom_range(0, 1), 2'($urandom_range(0, 3)),
           $urandom_range(0, 1), rand_sample(), rand_sample());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
